linebuff_ctrl: RTL

- Sequences the single-filter line buffer (one input flop plus tapped shift chain) for one feature-map frame of IMG_ROWS x IMG_COLS pixels.
- Accepts pixels from the upstream stream handshake and drives the buffer shift enable.
- Tracks the row/column position of each accepted pixel and flags when the buffer taps hold a complete KERNEL x KERNEL window at the configured stride.
- Handshakes that window with the downstream convolution engine and stalls the buffer under backpressure.

---
 rtl/linebuff_ctrl_pkg.sv | 23 ++
 rtl/linebuff_ctrl_if.sv | 36 +++
 rtl/linebuff_ctrl_pos_cnt.sv | 62 ++++++
 rtl/linebuff_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/linebuff_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lenet_lb_pkg: shared definitions for the line buffer controller.
//   - lbc_state_e : controller FSM states (IDLE, RUN, DRAIN)
//   - out_dim()   : output map dimension for a given image/kernel/stride
//   - LENET_*     : default LeNet layer-1 sizes (32x32 input, 5x5 kernel, stride 1)
// -----------------------------------------------------------------------------
package lenet_lb_pkg;

  localparam int LENET_IMG    = 32;
  localparam int LENET_KERNEL = 5;
  localparam int LENET_STRIDE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lbc_state_e;

  function automatic int out_dim(input int img, input int kernel, input int stride);
    return (img - kernel) / stride + 1;
  endfunction

endpackage

// File: rtl/linebuff_ctrl_if.sv
// -----------------------------------------------------------------------------
// linebuff_ctrl_if: pixel-in and window-out handshakes of the line buffer
// controller.
//   master modport : controller side (receives in_valid/win_ready, drives the rest)
//   slave  modport : upstream source / downstream engine side
//   lbc_in_valid_i / lbc_in_ready_o   : upstream pixel handshake
//   lbc_lb_en_o                       : line buffer shift enable
//   lbc_win_valid_o / lbc_win_ready_i : downstream window handshake
//   lbc_win_row_o / lbc_win_col_o     : output-map coordinates of the window
// -----------------------------------------------------------------------------
interface linebuff_ctrl_if #(
  parameter int IMG_ROWS = lenet_lb_pkg::LENET_IMG,
  parameter int IMG_COLS = lenet_lb_pkg::LENET_IMG,
  parameter int ROW_W    = $clog2(IMG_ROWS),
  parameter int COL_W    = $clog2(IMG_COLS)
);

  logic             lbc_in_valid_i;
  logic             lbc_in_ready_o;
  logic             lbc_lb_en_o;
  logic             lbc_win_valid_o;
  logic             lbc_win_ready_i;
  logic [ROW_W-1:0] lbc_win_row_o;
  logic [COL_W-1:0] lbc_win_col_o;

  modport master (
    input  lbc_in_valid_i, lbc_win_ready_i,
    output lbc_in_ready_o, lbc_lb_en_o, lbc_win_valid_o, lbc_win_row_o, lbc_win_col_o
  );

  modport slave (
    output lbc_in_valid_i, lbc_win_ready_i,
    input  lbc_in_ready_o, lbc_lb_en_o, lbc_win_valid_o, lbc_win_row_o, lbc_win_col_o
  );

endinterface

// File: rtl/linebuff_ctrl_pos_cnt.sv
// -----------------------------------------------------------------------------
// lbc_pos_cnt: one wrapping position counter with stride phase and output-index
// counter. Used once for columns (step = accept) and once for rows
// (step = column wrap).
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous clear at frame start
//   step     : advance to the next position
//   idx      : output-map index of the window anchored at the current position
//   qual     : current position is a window position (past fill, phase 0)
//   wrap     : step taken at the last position (combinational)
// -----------------------------------------------------------------------------
module lbc_pos_cnt #(
  parameter int MAX    = 32,
  parameter int KERNEL = 5,
  parameter int STRIDE = 1,
  parameter int W      = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  output logic [W-1:0] idx,
  output logic         qual,
  output logic         wrap
);

  localparam int              PH_W      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [W-1:0]    POS_LAST  = W'(MAX - 1);
  localparam logic [W-1:0]    POS_FIRST = W'(KERNEL - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(STRIDE - 1);

  logic [W-1:0]    pos;
  logic [PH_W-1:0] phase;
  logic            in_range;

  // The first window position is KERNEL-1; phase counts strides from there.
  assign in_range = (pos >= POS_FIRST);
  assign qual     = in_range && (phase == '0);
  assign wrap     = step && (pos == POS_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pos   <= '0;
      phase <= '0;
      idx   <= '0;
    end else if (step) begin
      if (pos == POS_LAST) begin
        pos   <= '0;
        phase <= '0;
        idx   <= '0;
      end else begin
        pos <= pos + 1'b1;
        // idx moves past a window only after its anchor position is left
        if (qual)     idx   <= idx + 1'b1;
        if (in_range) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/linebuff_ctrl.sv
// -----------------------------------------------------------------------------
// linebuff_ctrl: sequences a single-filter line buffer over one IMG_ROWS x
// IMG_COLS frame and hands complete KERNEL x KERNEL windows (at STRIDE) to the
// downstream convolution engine.
//   lbc_clk, lbc_rst : clock, synchronous active-high reset
//   lbc_start_i      : frame start pulse (ignored unless IDLE)
//   bus              : pixel/window handshakes (linebuff_ctrl_if.master)
//   lbc_busy_o       : controller not IDLE
//   lbc_done_o       : pulse when the last window of the frame is consumed
//   lbc_stall_cnt_o  : RUN cycles with a pixel offered but refused
//                      (present only when LBC_PERF_CNT_EN is defined)
// -----------------------------------------------------------------------------
module linebuff_ctrl
  import lenet_lb_pkg::*;
#(
  parameter int IMG_ROWS = LENET_IMG,
  parameter int IMG_COLS = LENET_IMG,
  parameter int KERNEL   = LENET_KERNEL,
  parameter int STRIDE   = LENET_STRIDE,
  parameter int ROW_W    = $clog2(IMG_ROWS),
  parameter int COL_W    = $clog2(IMG_COLS)
) (
  input  logic             lbc_clk,
  input  logic             lbc_rst,
  input  logic             lbc_start_i,
  linebuff_ctrl_if.master  bus,
  output logic             lbc_busy_o,
  output logic             lbc_done_o
`ifdef LBC_PERF_CNT_EN
  ,
  output logic [31:0]      lbc_stall_cnt_o
`endif
);

  lbc_state_e       state;
  logic             win_valid;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;

  logic             in_ready, accept, start_frame, qualify, done_pulse;
  logic             c_qual, c_wrap, r_qual, r_wrap;
  logic [ROW_W-1:0] r_idx;
  logic [COL_W-1:0] c_idx;

  // A held (unconsumed) window stalls the input so the buffer taps stay put.
  assign in_ready    = (state == RUN) && !(win_valid && !bus.lbc_win_ready_i);
  assign accept      = bus.lbc_in_valid_i && in_ready;
  assign start_frame = (state == IDLE) && lbc_start_i;
  assign qualify     = accept && c_qual && r_qual;
  assign done_pulse  = (state == DRAIN) && (!win_valid || bus.lbc_win_ready_i);

  lbc_pos_cnt #(.MAX(IMG_COLS), .KERNEL(KERNEL), .STRIDE(STRIDE), .W(COL_W)) u_col (
    .clk   (lbc_clk),
    .rst   (lbc_rst),
    .clear (start_frame),
    .step  (accept),
    .idx   (c_idx),
    .qual  (c_qual),
    .wrap  (c_wrap)
  );

  lbc_pos_cnt #(.MAX(IMG_ROWS), .KERNEL(KERNEL), .STRIDE(STRIDE), .W(ROW_W)) u_row (
    .clk   (lbc_clk),
    .rst   (lbc_rst),
    .clear (start_frame),
    .step  (c_wrap),
    .idx   (r_idx),
    .qual  (r_qual),
    .wrap  (r_wrap)
  );

  always_ff @(posedge lbc_clk) begin
    if (lbc_rst) begin
      state     <= IDLE;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      unique case (state)
        IDLE:    if (lbc_start_i) state <= RUN;
        RUN:     if (r_wrap)      state <= DRAIN;  // last pixel accepted
        DRAIN:   if (done_pulse)  state <= IDLE;
        default:                  state <= IDLE;
      endcase

      // One-cycle delay matches the buffer's input flop.
      if (qualify) begin
        win_valid <= 1'b1;
        win_row   <= r_idx;
        win_col   <= c_idx;
      end else if (bus.lbc_win_ready_i) begin
        win_valid <= 1'b0;
      end
    end
  end

  assign bus.lbc_in_ready_o  = in_ready;
  assign bus.lbc_lb_en_o     = accept;
  assign bus.lbc_win_valid_o = win_valid;
  assign bus.lbc_win_row_o   = win_row;
  assign bus.lbc_win_col_o   = win_col;
  assign lbc_busy_o          = (state != IDLE);
  assign lbc_done_o          = done_pulse;

`ifdef LBC_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge lbc_clk) begin
    if (lbc_rst || start_frame) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && bus.lbc_in_valid_i && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign lbc_stall_cnt_o = stall_cnt;
`endif

endmodule
